// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 one-hot (or one-cold) decoder with enable and sticky coverage mask.
// Latency: 1 cycle from sampled en/in to out/out_valid; seen_mask updates on the same edge.
// Backpressure: none; accepts a new code every cycle, outputs are plain registers.
module decoder_3_to_8 #(
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] in,
  input  logic       clr_seen,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [7:0] seen_mask
);

  localparam logic [7:0] IDLE = ACTIVE_LOW_OUT ? 8'hFF : 8'h00;

  logic [7:0] onehot;
  logic [7:0] out_nxt;
  logic [7:0] seen_nxt;

  always_comb begin
    onehot   = 8'd1 << in;
    out_nxt  = IDLE;
    seen_nxt = seen_mask;
    if (en) begin
      out_nxt = ACTIVE_LOW_OUT ? ~onehot : onehot;
    end
    // A clear in the same cycle as a decode keeps only the current code.
    if (clr_seen) begin
      seen_nxt = en ? onehot : 8'h00;
    end else if (en) begin
      seen_nxt = seen_mask | onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= IDLE;
      out_valid <= 1'b0;
      seen_mask <= 8'h00;
    end else begin
      out       <= out_nxt;
      out_valid <= en;
      seen_mask <= seen_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Scoreboard bench for decoder_3_to_8: both output polarities driven from one stimulus stream.
module tb_decoder_3_to_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] in = 3'd0;
  logic       clr_seen = 1'b0;
  logic [7:0] out_hi, out_lo, seen_hi, seen_lo;
  logic       vld_hi, vld_lo;

  always #5 clk = ~clk;

  decoder_3_to_8 #(.ACTIVE_LOW_OUT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr_seen(clr_seen),
    .out(out_hi), .out_valid(vld_hi), .seen_mask(seen_hi)
  );

  decoder_3_to_8 #(.ACTIVE_LOW_OUT(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr_seen(clr_seen),
    .out(out_lo), .out_valid(vld_lo), .seen_mask(seen_lo)
  );

  typedef struct {
    logic [7:0] out_hi;
    logic [7:0] out_lo;
    logic       vld;
    logic [7:0] seen;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen_code[8];

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: which codes have been seen, and the line number that should be lit.
  task automatic step(input bit r, input bit e, input bit [2:0] c, input bit cl);
    exp_t x;
    int   sel;
    @(negedge clk);
    rst_n = r; en = e; in = c; clr_seen = cl;
    sel = -1;
    if (!r) begin
      foreach (seen_code[k]) seen_code[k] = 1'b0;
    end else begin
      if (cl) foreach (seen_code[k]) seen_code[k] = 1'b0;
      if (e) begin
        sel = int'(c);
        seen_code[sel] = 1'b1;
      end
    end
    x.vld  = (sel >= 0);
    x.seen = 8'h00;
    foreach (seen_code[k]) if (seen_code[k]) x.seen = x.seen + 8'(2 ** k);
    x.out_hi = (sel >= 0) ? 8'(2 ** sel) : 8'h00;
    x.out_lo = 8'hFF - x.out_hi;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are registered every cycle, so each edge retires one expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      cmp("out_hi", out_hi, x.out_hi);
      cmp("valid_hi", {7'd0, vld_hi}, {7'd0, x.vld});
      cmp("seen_hi", seen_hi, x.seen);
      cmp("out_lo", out_lo, x.out_lo);
      cmp("valid_lo", {7'd0, vld_lo}, {7'd0, x.vld});
      cmp("seen_lo", seen_lo, x.seen);
    end
  end

  initial begin
    // Reset held two cycles with en asserted
    step(1'b0, 1'b1, 3'd5, 1'b0);
    step(1'b0, 1'b1, 3'd5, 1'b0);
    // Exhaustive sweep
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 1'b0);
    // Enable gating
    step(1'b1, 1'b0, 3'd3, 1'b0);
    step(1'b1, 1'b1, 3'd3, 1'b0);
    // Clear interactions
    step(1'b1, 1'b1, 3'd2, 1'b1);
    step(1'b1, 1'b0, 3'd2, 1'b1);
    // Mid-stream reset and resume
    step(1'b1, 1'b1, 3'd6, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b0);
    step(1'b0, 1'b1, 3'd7, 1'b1);
    step(1'b1, 1'b1, 3'd1, 1'b0);
    // Active-low corner codes and idle
    step(1'b1, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b0);
    step(1'b1, 1'b0, 3'd4, 1'b0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
    end
    repeat (3) @(negedge clk);
    cmp("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3_to_8.md
Name: decoder_3_to_8

Overview:
Registered 3-to-8 one-hot decoder with enable. A 3-bit select code drives exactly one of eight output lines, one clock after capture. A sticky coverage mask records which codes have been decoded since reset or last clear. Used as a select/strobe generator for 8-way fan-out logic (chip selects, demux enables).

Parameters:
ACTIVE_LOW_OUT, 0, 0 = selected line driven 1, others 0; 1 = selected line driven 0, others 1 (out polarity only; seen_mask is always active-high)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  decode enable; when 0 no line is asserted
in  input  3  select code, 0..7
clr_seen  input  1  synchronous clear of seen_mask
out  output  8  registered one-hot (or one-cold) decode of in
out_valid  output  1  registered; 1 when out holds a decoded value
seen_mask  output  8  sticky record of decoded codes, bit k set once code k decoded

Behaviour:
- Single clock domain. All outputs are registers; no combinational path from inputs to outputs.
- Reset (rst_n=0 at rising edge): out = idle pattern (8'b0000_0000 if ACTIVE_LOW_OUT=0, 8'b1111_1111 if 1); out_valid=0; seen_mask=8'h00. Reset overrides en and clr_seen.
- Decode (rst_n=1, en=1): next out bit k asserted iff k == in; all other bits deasserted. ACTIVE_LOW_OUT=0: out = 1<<in (in=000 -> 0000_0001, in=111 -> 1000_0000). ACTIVE_LOW_OUT=1: out = ~(1<<in). out_valid=1.
- Idle (rst_n=1, en=0): out = idle pattern; out_valid=0. in ignored.
- Latency: exactly 1 cycle from sampled (en, in) to out/out_valid. Back-to-back codes each cycle produce back-to-back outputs; no bubbles.
- Invariant: when out_valid=1, exactly one bit of out is asserted; when out_valid=0, no bit is asserted.
- seen_mask update each rising edge (rst_n=1):
  - clr_seen=0, en=1: seen_mask |= (1<<in).
  - clr_seen=0, en=0: hold.
  - clr_seen=1, en=0: seen_mask = 0.
  - clr_seen=1, en=1: clear takes effect first, then current code is recorded: seen_mask = (1<<in).
- Reset asserted mid-stream: next edge forces reset values regardless of en/in; decoding resumes on the first edge with rst_n=1.
- in bits with X/Z are not required to be handled; the bench must drive known values.

Test Plan:
- Reset: rst_n=0 for 2 cycles, en=1, in=3'b101 -> out=8'h00, out_valid=0, seen_mask=8'h00 after each edge.
- Exhaustive sweep: rst_n=1, en=1, in = 0,1,...,7 one per cycle -> one cycle later out = 01,02,04,08,10,20,40,80 hex, out_valid=1; after the final code seen_mask=8'hFF.
- Enable gating: en=0 with in=3'b011 -> out=8'h00, out_valid=0, seen_mask unchanged; next cycle en=1, in=3'b011 -> out=8'h08, out_valid=1.
- Clear interaction: seen_mask=8'hFF, then clr_seen=1, en=1, in=3'b010 -> seen_mask=8'h04. Next cycle clr_seen=1, en=0 -> seen_mask=8'h00.
- Mid-stream reset: streaming in=6,7, assert rst_n=0 for one edge -> out=8'h00, out_valid=0, seen_mask=8'h00. Release with en=1, in=3'b001 -> out=8'h02 next edge.
- ACTIVE_LOW_OUT=1 build: reset -> out=8'hFF. en=1, in=3'b000 -> out=8'hFE. in=3'b111 -> out=8'h7F. en=0 -> out=8'hFF, out_valid=0.
